// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_sched_pkg.sv
// Shared types for the 1r1w bit-masked RAM scheduler: FSM states and write-grant encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bsg_mem_sched_pkg;

    // Scheduler phase: zeroing sweep after reset, then normal client service.
    typedef enum logic [0:0] {
        eInit = 1'b0,
        eRun  = 1'b1
    } state_e;

    // Which write requester owns the RAM write port this cycle.
    typedef enum logic [1:0] {
        eGrantW0   = 2'd0,
        eGrantW1   = 2'd1,
        eGrantNone = 2'd2
    } grant_e;

endpackage

// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_sched_if.sv
// Client and RAM-side bundle for the 1r1w bit-masked RAM scheduler.
// Latency: n/a (wires only).
// Backpressure: valid/yumi on both write requesters and the read requester.
interface bsg_mem_sched_if #(
    parameter int width_p      = 8,
    parameter int addr_width_p = 4
);
    logic                    w0_v_i;
    logic [width_p-1:0]      w0_mask_i;
    logic [addr_width_p-1:0] w0_addr_i;
    logic [width_p-1:0]      w0_data_i;
    logic                    w0_yumi_o;

    logic                    w1_v_i;
    logic [width_p-1:0]      w1_mask_i;
    logic [addr_width_p-1:0] w1_addr_i;
    logic [width_p-1:0]      w1_data_i;
    logic                    w1_yumi_o;

    logic                    r_v_i;
    logic [addr_width_p-1:0] r_addr_i;
    logic                    r_yumi_o;
    logic                    r_v_o;
    logic [width_p-1:0]      r_data_o;

    logic                    mem_w_v_o;
    logic [width_p-1:0]      mem_w_mask_o;
    logic [addr_width_p-1:0] mem_w_addr_o;
    logic [width_p-1:0]      mem_w_data_o;
    logic                    mem_r_v_o;
    logic [addr_width_p-1:0] mem_r_addr_o;
    logic [width_p-1:0]      mem_r_data_i;
    logic                    init_done_o;

    // Scheduler side.
    modport slave (
        input  w0_v_i, w0_mask_i, w0_addr_i, w0_data_i,
        input  w1_v_i, w1_mask_i, w1_addr_i, w1_data_i,
        input  r_v_i, r_addr_i, mem_r_data_i,
        output w0_yumi_o, w1_yumi_o, r_yumi_o, r_v_o, r_data_o,
        output mem_w_v_o, mem_w_mask_o, mem_w_addr_o, mem_w_data_o,
        output mem_r_v_o, mem_r_addr_o, init_done_o
    );

    // Client pipelines plus RAM side.
    modport master (
        output w0_v_i, w0_mask_i, w0_addr_i, w0_data_i,
        output w1_v_i, w1_mask_i, w1_addr_i, w1_data_i,
        output r_v_i, r_addr_i, mem_r_data_i,
        input  w0_yumi_o, w1_yumi_o, r_yumi_o, r_v_o, r_data_o,
        input  mem_w_v_o, mem_w_mask_o, mem_w_addr_o, mem_w_data_o,
        input  mem_r_v_o, mem_r_addr_o, init_done_o
    );
endinterface

// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_sched_rr2.sv
// Two-input round-robin arbiter with registered last-grant pointer and per-input inhibit.
// Latency: combinational grant; pointer advances at the edge ending a granted cycle.
// Backpressure: an inhibited or idle input is simply skipped; the other may still win.
module bsg_mem_sched_rr2
    import bsg_mem_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic [1:0] v_i,
    input  logic [1:0] inhibit_i,
    output grant_e     grant_o
);
    // Pointer resets to "w1 granted last" so w0 wins the first tie.
    logic       last_w1_q;
    logic       last_w1_d;
    logic [1:0] req;

    // Eligible requests this cycle.
    always_comb begin
        req = v_i & ~inhibit_i & {2{en_i}};
    end

    // Single requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        grant_o = eGrantNone;
        if (req == 2'b11) begin
            grant_o = last_w1_q ? eGrantW0 : eGrantW1;
        end else if (req[0]) begin
            grant_o = eGrantW0;
        end else if (req[1]) begin
            grant_o = eGrantW1;
        end
    end

    // Pointer follows whoever actually got the port.
    always_comb begin
        last_w1_d = last_w1_q;
        if (grant_o == eGrantW0) begin
            last_w1_d = 1'b0;
        end else if (grant_o == eGrantW1) begin
            last_w1_d = 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_w1_q <= 1'b1;
        end else begin
            last_w1_q <= last_w1_d;
        end
    end
endmodule

// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_sched.sv
// Shares a 1r1w bit-masked RAM: RR between two writers, one reader, same-address collisions blocked; optional zero sweep (BSG_MEM_SCHED_INIT_EN).
// Latency: write lands at the edge ending the yumi cycle; r_v_o one cycle after r_yumi_o.
// Backpressure: yumi is combinational from valids; a colliding read waits exactly one cycle, then has priority.
module bsg_mem_1r1w_sync_mask_write_bit_sched
    import bsg_mem_sched_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int els_p         = 16,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
)
(
    input  logic           clk_i,
    input  logic           reset_n_i,
    bsg_mem_sched_if.slave bus
);
    logic                     run;
    logic                     init_w_v;
    logic [addr_width_lp-1:0] init_w_addr;
    logic                     init_done;

`ifdef BSG_MEM_SCHED_INIT_EN
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    state_e                   state_q;
    state_e                   state_d;
    logic [addr_width_lp-1:0] init_cnt_q;
    logic [addr_width_lp-1:0] init_cnt_d;
    logic                     init_done_q;
    logic                     init_done_d;

    // Sweep one address per cycle; leave eInit after writing the last one.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == eInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == last_addr_lp) begin
                state_d    = eRun;
                init_cnt_d = '0;
            end
        end
        init_done_d = (state_d == eRun);
    end

    // Phase, sweep counter and done flag registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= eInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign run         = reset_n_i & (state_q == eRun);
    assign init_w_v    = reset_n_i & (state_q == eInit);
    assign init_w_addr = init_cnt_q;
    assign init_done   = init_done_q;
`else
    // No sweep: clients are served from the first cycle out of reset.
    assign run         = reset_n_i;
    assign init_w_v    = 1'b0;
    assign init_w_addr = '0;
    assign init_done   = 1'b1;
`endif

    logic [1:0]               inhibit;
    grant_e                   grant;
    logic [addr_width_lp-1:0] grant_addr;
    logic                     collide;
    logic                     r_yumi;
    logic                     read_prio_q;
    logic                     read_prio_d;
    logic                     r_v_q;
    logic                     r_v_d;

    // While a previously blocked read has priority, deny writes aimed at its address.
    always_comb begin
        inhibit[0] = read_prio_q & bus.r_v_i & (bus.w0_addr_i == bus.r_addr_i);
        inhibit[1] = read_prio_q & bus.r_v_i & (bus.w1_addr_i == bus.r_addr_i);
    end

    bsg_mem_sched_rr2 u_rr2 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (run),
        .v_i       ({bus.w1_v_i, bus.w0_v_i}),
        .inhibit_i (inhibit),
        .grant_o   (grant)
    );

    // Read acceptance: a read yields to a same-address write once, then wins.
    always_comb begin
        grant_addr = (grant == eGrantW1) ? bus.w1_addr_i : bus.w0_addr_i;
        collide    = ~read_prio_q & (grant != eGrantNone) & (grant_addr == bus.r_addr_i);
        r_yumi     = run & bus.r_v_i & ~collide;
    end

    // Priority is armed by a collision and dropped by any accepted read or a withdrawn read.
    always_comb begin
        read_prio_d = read_prio_q;
        if (!bus.r_v_i || r_yumi) begin
            read_prio_d = 1'b0;
        end else if (collide) begin
            read_prio_d = 1'b1;
        end
        r_v_d = r_yumi;
    end

    // Read-valid and priority registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            read_prio_q <= 1'b0;
            r_v_q       <= 1'b0;
        end else begin
            read_prio_q <= read_prio_d;
            r_v_q       <= r_v_d;
        end
    end

    // RAM write port: sweep during init, otherwise the granted requester.
    always_comb begin
        bus.mem_w_v_o    = 1'b0;
        bus.mem_w_mask_o = '0;
        bus.mem_w_addr_o = '0;
        bus.mem_w_data_o = '0;
        if (init_w_v) begin
            bus.mem_w_v_o    = 1'b1;
            bus.mem_w_mask_o = '1;
            bus.mem_w_addr_o = init_w_addr;
        end else if (grant == eGrantW0) begin
            bus.mem_w_v_o    = 1'b1;
            bus.mem_w_mask_o = bus.w0_mask_i;
            bus.mem_w_addr_o = bus.w0_addr_i;
            bus.mem_w_data_o = bus.w0_data_i;
        end else if (grant == eGrantW1) begin
            bus.mem_w_v_o    = 1'b1;
            bus.mem_w_mask_o = bus.w1_mask_i;
            bus.mem_w_addr_o = bus.w1_addr_i;
            bus.mem_w_data_o = bus.w1_data_i;
        end
    end

    // Handshake returns, RAM read port and read-data passthrough.
    always_comb begin
        bus.w0_yumi_o    = (grant == eGrantW0);
        bus.w1_yumi_o    = (grant == eGrantW1);
        bus.r_yumi_o     = r_yumi;
        bus.mem_r_v_o    = r_yumi;
        bus.mem_r_addr_o = bus.r_addr_i;
        bus.r_v_o        = r_v_q;
        bus.r_data_o     = bus.mem_r_data_i;
        bus.init_done_o  = init_done;
    end
endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_bit_sched.sv
// Randomized and directed bench for the 1r1w bit-masked RAM scheduler against a behavioural model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: requesters hold valid and payload until yumi is observed.
module tb_bsg_mem_1r1w_sync_mask_write_bit_sched;
    localparam int W = 8;
    localparam int E = 16;
    localparam int A = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_mem_sched_if #(.width_p(W), .addr_width_p(A)) bus ();

    bsg_mem_1r1w_sync_mask_write_bit_sched #(.width_p(W), .els_p(E)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    // Environment RAM: synchronous read, per-bit masked write.
    logic [W-1:0] ram [E];
    logic [W-1:0] ram_rd;
    initial begin
        for (int i = 0; i < E; i++) ram[i] = '0;
        ram_rd = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_w_v_o)
            ram[bus.mem_w_addr_o] <= (ram[bus.mem_w_addr_o] & ~bus.mem_w_mask_o) |
                                     (bus.mem_w_data_o & bus.mem_w_mask_o);
        if (bus.mem_r_v_o) ram_rd <= ram[bus.mem_r_addr_o];
    end
    assign bus.mem_r_data_i = ram_rd;

    // Reference model state.
    logic [W-1:0] mdl_mem [E];
    int           init_left = 0;
    bit           mdl_done;
    bit           last_w1 = 1'b1;
    bit           prio = 1'b0;
    bit           rv_pend = 1'b0;
    logic [W-1:0] rdata_pend = '0;

    // Observations from the most recent cycle, used by stimulus and directed checks.
    logic         obs_w0y, obs_w1y, obs_ry, obs_rv, obs_wv;
    logic [W-1:0] obs_rdata;
    logic [A-1:0] obs_waddr;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: predict, compare on negedge, advance model on posedge.
    task automatic tick();
        int           g;
        bit           c0, c1, coll, e_ry, e_wv;
        logic [A-1:0] gaddr, e_waddr;
        logic [W-1:0] e_wmask, e_wdata, gdata, gmask;
        @(negedge clk);
        obs_w0y = bus.w0_yumi_o; obs_w1y = bus.w1_yumi_o; obs_ry = bus.r_yumi_o;
        obs_rv = bus.r_v_o; obs_rdata = bus.r_data_o;
        obs_wv = bus.mem_w_v_o; obs_waddr = bus.mem_w_addr_o;
        g = 2; coll = 0; e_ry = 0; e_wv = 0;
        e_waddr = '0; e_wmask = '0; e_wdata = '0; gaddr = '0; gdata = '0; gmask = '0;
        if (!rst_n) begin
            g = 2;
        end else if (init_left > 0) begin
            e_wv = 1; e_waddr = A'(E - init_left); e_wmask = '1; e_wdata = '0;
        end else begin
            c0 = bus.w0_v_i && !(prio && bus.r_v_i && bus.w0_addr_i == bus.r_addr_i);
            c1 = bus.w1_v_i && !(prio && bus.r_v_i && bus.w1_addr_i == bus.r_addr_i);
            if (c0 && c1) g = last_w1 ? 0 : 1;
            else if (c0)  g = 0;
            else if (c1)  g = 1;
            if (g == 0) begin gaddr = bus.w0_addr_i; gdata = bus.w0_data_i; gmask = bus.w0_mask_i; end
            if (g == 1) begin gaddr = bus.w1_addr_i; gdata = bus.w1_data_i; gmask = bus.w1_mask_i; end
            coll = bus.r_v_i && !prio && g != 2 && gaddr == bus.r_addr_i;
            e_ry = bus.r_v_i && !coll;
            e_wv = (g != 2); e_waddr = gaddr; e_wmask = gmask; e_wdata = gdata;
        end
        check_val("w0_yumi", obs_w0y, 32'(g == 0));
        check_val("w1_yumi", obs_w1y, 32'(g == 1));
        check_val("r_yumi", obs_ry, 32'(e_ry));
        check_val("mem_r_v", bus.mem_r_v_o, 32'(e_ry));
        if (e_ry) check_val("mem_r_addr", bus.mem_r_addr_o, 32'(bus.r_addr_i));
        check_val("mem_w_v", obs_wv, 32'(e_wv));
        if (e_wv) begin
            check_val("mem_w_addr", obs_waddr, 32'(e_waddr));
            check_val("mem_w_mask", bus.mem_w_mask_o, 32'(e_wmask));
            check_val("mem_w_data", bus.mem_w_data_o, 32'(e_wdata));
        end
        check_val("r_v_o", obs_rv, 32'(rv_pend));
        if (rv_pend) check_val("r_data", obs_rdata, 32'(rdata_pend));
        check_val("init_done", bus.init_done_o, 32'(mdl_done));
        @(posedge clk);
        if (!rst_n) begin
            last_w1 = 1; prio = 0; rv_pend = 0;
`ifdef BSG_MEM_SCHED_INIT_EN
            init_left = E; mdl_done = 0;
`endif
        end else if (init_left > 0) begin
            mdl_mem[E - init_left] = '0;
            init_left--;
            rv_pend = 0;
            if (init_left == 0) mdl_done = 1;
        end else begin
            rv_pend = e_ry;
            if (e_ry) rdata_pend = mdl_mem[bus.r_addr_i];
            if (g != 2) begin
                mdl_mem[gaddr] = (mdl_mem[gaddr] & ~gmask) | (gdata & gmask);
                last_w1 = (g == 1);
            end
            if (!bus.r_v_i || e_ry) prio = 0;
            else if (coll) prio = 1;
        end
        #1;
    endtask

    initial begin
`ifdef BSG_MEM_SCHED_INIT_EN
        mdl_done = 0;
`else
        mdl_done = 1;
`endif
        for (int i = 0; i < E; i++) mdl_mem[i] = '0;
        bus.w0_v_i = 0; bus.w0_mask_i = '0; bus.w0_addr_i = '0; bus.w0_data_i = '0;
        bus.w1_v_i = 0; bus.w1_mask_i = '0; bus.w1_addr_i = '0; bus.w1_data_i = '0;
        bus.r_v_i = 0; bus.r_addr_i = '0;
        #1;
        // Reset cycle with requests pending: everything must stay quiet.
        bus.w0_v_i = 1; bus.w1_v_i = 1; bus.r_v_i = 1; bus.r_addr_i = 4'd2;
        tick();
        check_val("rst_w0_yumi", obs_w0y, 0);
        check_val("rst_r_v_o", obs_rv, 0);
        rst_n = 1;
        bus.w0_addr_i = 4'd8; bus.w0_mask_i = '1; bus.w0_data_i = 8'h11;
        bus.w1_addr_i = 4'd9; bus.w1_mask_i = '1; bus.w1_data_i = 8'h22;
`ifdef BSG_MEM_SCHED_INIT_EN
        // Sweep phase: clients locked out, model checks addresses 0..E-1.
        for (int k = 0; k < E; k++) begin
            tick();
            check_val("init_lockout", obs_w0y | obs_w1y | obs_ry, 0);
        end
        check_val("init_done_c17", bus.init_done_o, 1);
`else
        check_val("init_done_nomacro", bus.init_done_o, 1);
`endif
        bus.r_v_i = 0;
        // Tie-break: w0 wins first, then alternation.
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("tie_w0", obs_w0y, 32'(k % 2 == 0));
            check_val("tie_w1", obs_w1y, 32'(k % 2 == 1));
            if (obs_w0y) bus.w0_data_i = W'($urandom);
            if (obs_w1y) bus.w1_data_i = W'($urandom);
        end
        bus.w1_v_i = 0;
        // Collision on address 5.
        bus.w0_v_i = 1; bus.w0_addr_i = 4'd5; bus.w0_data_i = 8'hA5; bus.w0_mask_i = '1;
        bus.r_v_i = 1; bus.r_addr_i = 4'd5;
        tick();
        check_val("coll_c1_w0y", obs_w0y, 1);
        check_val("coll_c1_ry", obs_ry, 0);
        bus.w0_data_i = 8'h3C;
        tick();
        check_val("coll_c2_ry", obs_ry, 1);
        check_val("coll_c2_w0y", obs_w0y, 0);
        bus.r_v_i = 0;
        tick();
        check_val("coll_c3_rv", obs_rv, 1);
        check_val("coll_c3_rdata", obs_rdata, 8'hA5);
        bus.w0_v_i = 0;
        // Bit mask on address 3.
        bus.w0_v_i = 1; bus.w0_addr_i = 4'd3; bus.w0_data_i = 8'hFF; bus.w0_mask_i = 8'hFF;
        tick();
        bus.w0_data_i = 8'h00; bus.w0_mask_i = 8'h0F;
        tick();
        bus.w0_v_i = 0; bus.r_v_i = 1; bus.r_addr_i = 4'd3;
        tick();
        bus.r_v_i = 0;
        tick();
        check_val("mask_rv", obs_rv, 1);
        check_val("mask_rdata", obs_rdata, 8'hF0);
        // Mid-run reset with a read in flight.
        bus.r_v_i = 1; bus.r_addr_i = 4'd7;
        tick();
        bus.r_v_i = 0; rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        check_val("midrst_rv", obs_rv, 0);
`ifdef BSG_MEM_SCHED_INIT_EN
        check_val("midrst_init_v", obs_wv, 1);
        check_val("midrst_init_addr", obs_waddr, 0);
        for (int k = 1; k < E; k++) tick();
`endif
        // Randomized traffic on a small address window to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            if (!bus.w0_v_i || obs_w0y) begin
                bus.w0_v_i = ($urandom_range(0, 2) != 0);
                bus.w0_addr_i = A'($urandom_range(0, 3));
                bus.w0_data_i = W'($urandom); bus.w0_mask_i = W'($urandom);
            end
            if (!bus.w1_v_i || obs_w1y) begin
                bus.w1_v_i = ($urandom_range(0, 2) != 0);
                bus.w1_addr_i = A'($urandom_range(0, 3));
                bus.w1_data_i = W'($urandom); bus.w1_mask_i = W'($urandom);
            end
            if (!bus.r_v_i || obs_ry) begin
                bus.r_v_i = ($urandom_range(0, 2) != 0);
                bus.r_addr_i = A'($urandom_range(0, 3));
            end
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1;
        bus.w0_v_i = 0; bus.w1_v_i = 0; bus.r_v_i = 0;
        for (int k = 0; k < E + 2; k++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
